flit_demux_1_4: RTL and testbench
=================================

Name: flit_demux_1_4

Overview:
- Output-side counterpart of the router's 4:1 flit mux. Takes one flit stream and steers whole packets to one of four output ports.
- Routing is wormhole style: the head flit's destination field locks a port, and that port is held until the tail flit has passed.
- Each output has a one-deep registered stage with a valid/ready handshake, so the block sits between the input buffer and the per-direction links of the router.

Parameters:
- DATA_WIDTH, 17, flit width. Bits [DATA_WIDTH-1:DATA_WIDTH-2] are the flit type; bits [1:0] of a head flit are the destination port.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- data_i  input  DATA_WIDTH  incoming flit.
- valid_i  input  1  data_i is valid.
- ready_o  output  1  the block accepts data_i this cycle.
- data1_o..data4_o  output  DATA_WIDTH each  output port flit registers.
- valid1_o..valid4_o  output  1 each  output port flit valid.
- ready1_i..ready4_i  input  1 each  downstream accepts the port's flit.
- busy_o  output  1  a packet is in progress (state ROUTE).
- port_o  output  2  locked destination port; meaningful when busy_o=1.
- err_o  output  1  sticky protocol error flag.

Behaviour:
- Reset values, applied asynchronously on rst_n=0: state=IDLE, all validk_o=0, all datak_o=0, port_o=0, busy_o=0, err_o=0.
- Flit type encoding: 2'b01 HEAD, 2'b00 BODY, 2'b10 TAIL, 2'b11 SINGLE (head and tail in one flit).
- Destination encoding matches the mux control: 00 gives port 1, 01 port 2, 10 port 3, 11 port 4.
- Transfer: a flit is accepted when valid_i=1 and ready_o=1 on a clock edge.
- Latency: an accepted flit appears on its target datak_o/validk_o one cycle after acceptance.
- Port k "can load" when validk_o=0 or readyk_i=1. This lets a full register drain and refill in the same cycle, so sustained throughput is 1 flit/cycle.
- Port k drains when validk_o=1 and readyk_i=1. validk_o clears unless the same edge loads a new flit.
- datak_o holds its value while validk_o=1 and readyk_i=0, and is stable under back-pressure.

State IDLE:
- ready_o = (valid_i=0) OR (flit is HEAD/SINGLE AND its destination port can load) OR (flit is BODY/TAIL).
- ready_o is combinational from data_i and the readyk_i inputs.
- Accepted HEAD: loads its destination port, latches port_o, and moves to ROUTE.
- Accepted SINGLE: loads its destination port and stays in IDLE.
- Accepted BODY/TAIL: consumed and discarded, nothing is forwarded, err_o is set to 1.

State ROUTE:
- ready_o = locked port can load.
- Every accepted flit goes to the locked port. The destination field is ignored.
- Accepted TAIL or SINGLE: forwarded, then return to IDLE on the same edge. A head flit can be accepted on the very next cycle.
- Accepted HEAD: still forwarded to the locked port, err_o is set, and the state stays ROUTE.

Other rules:
- valid_i=0: no state change. Output ports still drain normally.
- err_o is sticky; only reset clears it.
- Reset mid-packet: the in-flight packet is abandoned, all valid flags clear immediately, and the block returns to IDLE.
- Only one port loads per cycle; any or all ports may drain in the same cycle.

Decomposition:
- Shared package noc_pkg:
  - flit_type_t enum (HEAD, BODY, TAIL, SINGLE);
  - constants TYPE_MSB/TYPE_LSB and DEST_MSB/DEST_LSB;
  - state enum {IDLE, ROUTE}.
- Sub-module out_stage: a one-deep valid/ready register with load_i, data_i, ready_i, valid_o, data_o and can_load_o. It is instantiated four times by a generate loop.
- The top level holds the FSM, the port lock and the error logic.

Test Plan:
- SINGLE flit 17'h1_8003 (type 11, dest 11) sent from IDLE with all ready=1 → valid4_o=1 the next cycle with data4_o=17'h1_8003; the other ports stay 0; busy_o stays 0.
- HEAD (dest 01), BODY 17'h00AAA, TAIL 17'h10555 back-to-back with ready2_i=1 → port 2 shows the 3 flits on consecutive cycles; busy_o=1 for 2 cycles; port_o=01; IDLE after the tail.
- Same packet with ready2_i held at 0 after the head → ready_o=0; data2_o stays at the head flit. Releasing ready2_i → the remaining flits follow with no loss or duplication.
- BODY flit in IDLE → ready_o=1, flit dropped, no validk_o asserts, err_o=1 and stays 1 until rst_n pulses.
- Packet to port 3 with ready3_i=0, then a second packet to port 1 → ready_o stays 0 for the port-1 head until port 3 can load and its tail passes. No interleaving.
- rst_n=0 asserted mid-packet with valid3_o=1 → all outputs go to 0 immediately. After release, a new HEAD to port 1 routes correctly.

Source files
------------

// File: rtl/noc_pkg.sv
// Shared flit definitions for the router's mux/demux datapath.
// Flit type sits in the top two bits of a flit; the destination port sits in the bottom two.
package noc_pkg;

  localparam int FLIT_WIDTH = 17;

  localparam int TYPE_MSB = FLIT_WIDTH - 1;
  localparam int TYPE_LSB = FLIT_WIDTH - 2;
  localparam int DEST_MSB = 1;
  localparam int DEST_LSB = 0;

  typedef enum logic [1:0] {
    FT_BODY   = 2'b00,
    FT_HEAD   = 2'b01,
    FT_TAIL   = 2'b10,
    FT_SINGLE = 2'b11
  } flit_type_t;

  typedef enum logic {
    IDLE  = 1'b0,
    ROUTE = 1'b1
  } state_t;

endpackage

// File: rtl/flit_demux_1_4_out_stage.sv
// One-deep registered output stage with a valid/ready handshake.
// A full register can drain and reload on the same edge.
module out_stage #(
  parameter int DATA_WIDTH = 17
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  ready_i,
  output logic                  valid_o,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  can_load_o
);

  assign can_load_o = !valid_o || ready_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_o <= 1'b0;
      data_o  <= '0;
    end else if (load_i) begin
      valid_o <= 1'b1;
      data_o  <= data_i;
    end else if (ready_i) begin
      valid_o <= 1'b0;
    end
  end

endmodule

// File: rtl/flit_demux_1_4.sv
// 1:4 wormhole flit demux: a head flit locks an output port until its tail passes.
// Each output is a one-deep valid/ready register stage.
//
// state | meaning
// IDLE  | waiting for a head/single flit; stray body/tail flits are dropped and flagged
// ROUTE | packet in progress; every flit goes to the locked port
module flit_demux_1_4
  import noc_pkg::*;
#(
  parameter int DATA_WIDTH = FLIT_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  valid_i,
  output logic                  ready_o,
  output logic [DATA_WIDTH-1:0] data1_o,
  output logic [DATA_WIDTH-1:0] data2_o,
  output logic [DATA_WIDTH-1:0] data3_o,
  output logic [DATA_WIDTH-1:0] data4_o,
  output logic                  valid1_o,
  output logic                  valid2_o,
  output logic                  valid3_o,
  output logic                  valid4_o,
  input  logic                  ready1_i,
  input  logic                  ready2_i,
  input  logic                  ready3_i,
  input  logic                  ready4_i,
  output logic                  busy_o,
  output logic [1:0]            port_o,
  output logic                  err_o
);

  state_t                state_q, state_d;
  logic [1:0]            port_q, port_d;
  logic                  err_q, err_set;
  logic                  rdy;
  logic [3:0]            load, can_load, valid_v, ready_v;
  logic [DATA_WIDTH-1:0] data_v [4];
  flit_type_t            ftype;
  logic [1:0]            dest;
  logic                  opens_packet;

  assign ftype        = flit_type_t'(data_i[DATA_WIDTH-1 -: (TYPE_MSB - TYPE_LSB + 1)]);
  assign dest         = data_i[DEST_MSB:DEST_LSB];
  assign opens_packet = (ftype == FT_HEAD) || (ftype == FT_SINGLE);
  assign ready_v      = {ready4_i, ready3_i, ready2_i, ready1_i};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      port_q  <= 2'b00;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      port_q  <= port_d;
      if (err_set) err_q <= 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    port_d  = port_q;
    load    = '0;
    err_set = 1'b0;
    rdy     = 1'b1;
    case (state_q)
      IDLE: begin
        // Body/tail flits are always swallowed so a broken stream cannot stall the input.
        if (valid_i && opens_packet) rdy = can_load[dest];
        if (valid_i && rdy) begin
          if (opens_packet) begin
            load[dest] = 1'b1;
            if (ftype == FT_HEAD) begin
              state_d = ROUTE;
              port_d  = dest;
            end
          end else begin
            err_set = 1'b1;
          end
        end
      end
      ROUTE: begin
        rdy = can_load[port_q];
        if (valid_i && rdy) begin
          load[port_q] = 1'b1;
          if (ftype == FT_TAIL || ftype == FT_SINGLE) state_d = IDLE;
          if (ftype == FT_HEAD) err_set = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  for (genvar k = 0; k < 4; k++) begin : g_port
    out_stage #(.DATA_WIDTH(DATA_WIDTH)) u_stage (
      .clk        (clk),
      .rst_n      (rst_n),
      .load_i     (load[k]),
      .data_i     (data_i),
      .ready_i    (ready_v[k]),
      .valid_o    (valid_v[k]),
      .data_o     (data_v[k]),
      .can_load_o (can_load[k])
    );
  end

  assign ready_o  = rdy;
  assign busy_o   = (state_q == ROUTE);
  assign port_o   = port_q;
  assign err_o    = err_q;
  assign valid1_o = valid_v[0];
  assign valid2_o = valid_v[1];
  assign valid3_o = valid_v[2];
  assign valid4_o = valid_v[3];
  assign data1_o  = data_v[0];
  assign data2_o  = data_v[1];
  assign data3_o  = data_v[2];
  assign data4_o  = data_v[3];

endmodule

// File: tb/tb_flit_demux_1_4.sv
// Scoreboard bench for flit_demux_1_4: per-port expected queues filled on acceptance,
// checked by an independent monitor on every falling edge.
module tb_flit_demux_1_4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [16:0] data_i;
  logic        valid_i;
  logic        ready_o;
  logic [16:0] data1_o, data2_o, data3_o, data4_o;
  logic        valid1_o, valid2_o, valid3_o, valid4_o;
  logic [3:0]  rdy;
  logic        busy_o;
  logic [1:0]  port_o;
  logic        err_o;

  int checks = 0;
  int failures = 0;

  logic        rdy_rand = 1'b0;
  int          rdy_pct = 70;

  // reference model: packet lock, sticky error, expected contents of each port register
  logic [16:0] q [4][$];
  logic        m_locked = 1'b0;
  int          m_port = 0;
  logic        m_err = 1'b0;

  always #5 clk = ~clk;

  flit_demux_1_4 dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .data_i   (data_i),
    .valid_i  (valid_i),
    .ready_o  (ready_o),
    .data1_o  (data1_o),
    .data2_o  (data2_o),
    .data3_o  (data3_o),
    .data4_o  (data4_o),
    .valid1_o (valid1_o),
    .valid2_o (valid2_o),
    .valid3_o (valid3_o),
    .valid4_o (valid4_o),
    .ready1_i (rdy[0]),
    .ready2_i (rdy[1]),
    .ready3_i (rdy[2]),
    .ready4_i (rdy[3]),
    .busy_o   (busy_o),
    .port_o   (port_o),
    .err_o    (err_o)
  );

  logic [16:0] dq [4];
  logic [3:0]  vq;
  assign dq[0] = data1_o;
  assign dq[1] = data2_o;
  assign dq[2] = data3_o;
  assign dq[3] = data4_o;
  assign vq    = {valid4_o, valid3_o, valid2_o, valid1_o};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // monitor / scoreboard
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        chk("rst_valid", {28'b0, vq}, 32'h0);
        chk("rst_data", {15'b0, dq[0] | dq[1] | dq[2] | dq[3]}, 32'h0);
        chk("rst_busy_port_err", {29'b0, busy_o, port_o, err_o}, 32'h0);
        for (int k = 0; k < 4; k++) q[k].delete();
        m_locked = 1'b0;
        m_port   = 0;
        m_err    = 1'b0;
      end else begin
        logic [3:0] can;
        logic       er;
        logic [1:0] t;
        int         d;
        for (int k = 0; k < 4; k++) begin
          chk($sformatf("valid%0d", k + 1), {31'b0, vq[k]}, {31'b0, q[k].size() != 0});
          if (vq[k] && q[k].size() != 0) chk($sformatf("data%0d", k + 1), {15'b0, dq[k]}, {15'b0, q[k][0]});
          can[k] = (q[k].size() == 0) || rdy[k];
        end
        chk("err", {31'b0, err_o}, {31'b0, m_err});
        chk("busy", {31'b0, busy_o}, {31'b0, m_locked});
        if (m_locked) chk("port", {30'b0, port_o}, m_port);
        t = data_i[16:15];
        d = int'(data_i[1:0]);
        if (m_locked) er = can[m_port];
        else if (!valid_i) er = 1'b1;
        else if (t == 2'b01 || t == 2'b11) er = can[d];
        else er = 1'b1;
        chk("ready_o", {31'b0, ready_o}, {31'b0, er});
        for (int k = 0; k < 4; k++)
          if (q[k].size() != 0 && rdy[k]) void'(q[k].pop_front());
        if (valid_i && er) begin
          if (m_locked) begin
            q[m_port].push_back(data_i);
            if (t == 2'b10 || t == 2'b11) m_locked = 1'b0;
            if (t == 2'b01) m_err = 1'b1;
          end else if (t == 2'b01 || t == 2'b11) begin
            q[d].push_back(data_i);
            if (t == 2'b01) begin
              m_locked = 1'b1;
              m_port   = d;
            end
          end else begin
            m_err = 1'b1;
          end
        end
      end
    end
  end

  // random downstream back-pressure
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rdy_rand)
        for (int k = 0; k < 4; k++) rdy[k] = ($urandom_range(0, 99) < rdy_pct);
    end
  end

  task automatic send(input logic [16:0] f);
    bit ok = 1'b0;
    valid_i = 1'b1;
    data_i  = f;
    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      if (ready_o) begin
        ok = 1'b1;
        break;
      end
    end
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL send_timeout: flit %h not accepted, expected acceptance within 300 cycles", f);
    end
    @(posedge clk);
    #1;
    valid_i = 1'b0;
  endtask

  task automatic idle(input int n);
    valid_i = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic reset_pulse();
    rst_n = 1'b0;
    #1;
    chk("async_reset_valid", {28'b0, vq}, 32'h0);
    idle(2);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n   = 1'b0;
    valid_i = 1'b0;
    data_i  = '0;
    rdy     = 4'hF;
    idle(3);
    rst_n = 1'b1;
    idle(1);

    // single flit to port 4
    send(17'h1_8003);
    chk("single_valid4", {31'b0, valid4_o}, 32'h1);
    chk("single_data4", {15'b0, data4_o}, 32'h1_8003);
    chk("single_others", {29'b0, valid3_o, valid2_o, valid1_o}, 32'h0);
    chk("single_busy", {31'b0, busy_o}, 32'h0);
    idle(2);

    // head/body/tail to port 2, back-to-back
    send(17'h0_8001);
    chk("pkt_busy", {31'b0, busy_o}, 32'h1);
    chk("pkt_port", {30'b0, port_o}, 32'h1);
    send(17'h0_0AAA);
    send(17'h1_0555);
    chk("pkt_idle_after_tail", {31'b0, busy_o}, 32'h0);
    idle(3);

    // back-pressure on port 2 after the head
    send(17'h0_8001);
    rdy[1] = 1'b0;
    fork
      begin
        send(17'h0_0AAA);
        send(17'h1_0555);
      end
      begin
        repeat (5) @(posedge clk);
        #1;
        chk("bp_ready_low", {31'b0, ready_o}, 32'h0);
        chk("bp_data2_hold", {15'b0, data2_o}, 32'h0_8001);
        rdy[1] = 1'b1;
      end
    join
    idle(3);

    // stray body in IDLE
    send(17'h0_0123);
    idle(2);
    chk("stray_err", {31'b0, err_o}, 32'h1);
    idle(5);
    chk("stray_err_sticky", {31'b0, err_o}, 32'h1);
    reset_pulse();
    idle(1);
    chk("err_cleared", {31'b0, err_o}, 32'h0);

    // packet to stalled port 3, then a packet to port 1
    rdy[2] = 1'b0;
    fork
      begin
        send(17'h0_8002);
        send(17'h0_0777);
        send(17'h1_0002);
        send(17'h0_8000);
        send(17'h1_0000);
      end
      begin
        repeat (4) @(posedge clk);
        #1;
        chk("stall_ready_low", {31'b0, ready_o}, 32'h0);
        chk("stall_valid3", {31'b0, valid3_o}, 32'h1);
        rdy[2] = 1'b1;
      end
    join
    idle(3);

    // reset in the middle of a packet
    rdy[2] = 1'b0;
    send(17'h0_8002);
    idle(1);
    chk("mid_valid3", {31'b0, valid3_o}, 32'h1);
    reset_pulse();
    rdy = 4'hF;
    send(17'h0_8000);
    send(17'h1_0000);
    idle(3);

    // randomized traffic under random back-pressure
    rdy_rand = 1'b1;
    for (int p = 0; p < 250; p++) begin
      int r = $urandom_range(0, 99);
      if (p % 50 == 0) rdy_pct = $urandom_range(30, 100);
      if (r < 8) begin
        send({($urandom_range(0, 1) != 0) ? 2'b10 : 2'b00, 15'($urandom)});
      end else if (r < 30) begin
        send({2'b11, 15'($urandom)});
      end else begin
        int nb = $urandom_range(0, 3);
        send({2'b01, 15'($urandom)});
        for (int b = 0; b < nb; b++) begin
          if ($urandom_range(0, 19) == 0) send({2'b01, 15'($urandom)});
          else send({2'b00, 15'($urandom)});
        end
        send({($urandom_range(0, 4) == 0) ? 2'b11 : 2'b10, 15'($urandom)});
      end
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
    end
    rdy_rand = 1'b0;
    rdy = 4'hF;
    idle(5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
